// File: rtl/acum_mac.sv
// Multiply-accumulate sequencer for the FIR datapath: one tap per cycle over an
// M-tap delay line, with the ban_Adc/ban_Listo pair framing each result.
module acum_mac #(
  parameter int N     = 25,
  parameter int M     = 8,
  parameter int W_DIR = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [N-1:0]   muestra,
  input  logic                  muestra_lista,
  input  logic signed [N-1:0]   coef,
  output logic [W_DIR-1:0]      coef_dir,
  output logic signed [2*N-1:0] Acum,
  output logic                  ban_Adc,
  output logic                  ban_Listo,
  output logic                  ocupado,
  output logic                  ban_perdida
);

  typedef enum logic [1:0] {ESPERA = 2'd0, MAC = 2'd1, LISTO = 2'd2} estado_t;

  estado_t state_reg, state_next;

  logic [W_DIR-1:0]      k_reg;
  logic signed [N-1:0]   x_reg [M];
  logic signed [2*N-1:0] acum_reg;
  logic                  ban_adc_reg, ban_adc_next;
  logic                  ban_listo_reg, ban_listo_next;
  logic                  ocupado_reg, ocupado_next;
  logic                  perdida_reg, perdida_next;

  logic                  acepta;
  logic                  ultimo;
  logic signed [N-1:0]   x_sel;
  logic signed [2*N-1:0] coef_ext, x_ext, producto;

  assign acepta = (state_reg == ESPERA) && muestra_lista;
  assign ultimo = (k_reg == W_DIR'(M - 1));
  assign x_sel  = x_reg[k_reg];

  // Operands are sign-extended to 2N bits so the low 2N bits of the product
  // are the exact signed N x N result.
  assign coef_ext = {{N{coef[N-1]}}, coef};
  assign x_ext    = {{N{x_sel[N-1]}}, x_sel};
  assign producto = coef_ext * x_ext;

  // State register plus the registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ESPERA;
      ban_adc_reg   <= 1'b0;
      ban_listo_reg <= 1'b0;
      ocupado_reg   <= 1'b0;
      perdida_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ban_adc_reg   <= ban_adc_next;
      ban_listo_reg <= ban_listo_next;
      ocupado_reg   <= ocupado_next;
      perdida_reg   <= perdida_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ESPERA:  if (muestra_lista) state_next = MAC;
      MAC:     if (ultimo) state_next = LISTO;
      LISTO:   state_next = ESPERA;
      default: state_next = ESPERA;
    endcase
  end

  always_comb begin
    ban_adc_next   = acepta;
    ban_listo_next = (state_reg == MAC) && ultimo;
    ocupado_next   = (state_next != ESPERA);
    perdida_next   = perdida_reg | (muestra_lista && (state_reg != ESPERA));
  end

  // Tap index returns to 0 after the last tap so coef_dir idles at 0
  always_ff @(posedge clk) begin
    if (reset) begin
      k_reg    <= '0;
      acum_reg <= '0;
    end else if (acepta) begin
      k_reg    <= '0;
      acum_reg <= '0;
    end else if (state_reg == MAC) begin
      k_reg    <= ultimo ? '0 : k_reg + 1'b1;
      acum_reg <= acum_reg + producto;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < M; i++) x_reg[i] <= '0;
    end else if (acepta) begin
      x_reg[0] <= muestra;
      for (int i = 1; i < M; i++) x_reg[i] <= x_reg[i-1];
    end
  end

  assign coef_dir    = k_reg;
  assign Acum        = acum_reg;
  assign ban_Adc     = ban_adc_reg;
  assign ban_Listo   = ban_listo_reg;
  assign ocupado     = ocupado_reg;
  assign ban_perdida = perdida_reg;

endmodule

// File: doc/acum_mac.md
# acum_mac

Multiply-accumulate sequencer that drives the accumulator capture register of the FIR filter datapath. For each new ADC sample it shifts the sample into an M-tap delay line and computes one output over M cycles, one tap per cycle, reading coefficients from an external ROM. It produces the 2N-bit accumulator word together with the `ban_Adc`/`ban_Listo` handshake pair that the capture register consumes: `ban_Adc` opens capture and `ban_Listo` closes it.

## Interface
- `N`, 25: sample and coefficient width (signed, two's complement).
- `M`, 8: number of filter taps, 2 ≤ M ≤ 2^W_DIR.
- `W_DIR`, 3: coefficient address width.

- `clk` input, 1: single clock, all state updates on the rising edge.
- `reset` input, 1: synchronous, active-high.
- `muestra` input, N, signed: ADC sample; valid when `muestra_lista` = 1.
- `muestra_lista` input, 1: one-cycle strobe marking a new sample.
- `coef` input, N, signed: coefficient at `coef_dir`. Combinational ROM read, valid in the same cycle.
- `coef_dir` output, W_DIR: coefficient address.
- `Acum` output, 2N, signed: accumulator value.
- `ban_Adc` output, 1: one-cycle pulse at the start of accumulation.
- `ban_Listo` output, 1: one-cycle pulse when `Acum` holds the final result.
- `ocupado` output, 1: high while a computation is in progress.
- `ban_perdida` output, 1: sticky flag set when a sample is dropped.

## Operation
- Delay line `x[0..M-1]` of N-bit registers; `x[0]` holds the newest sample.
- Result: `Acum = Σ_{k=0}^{M-1} coef[k]·x[k]`.
- Arithmetic:
  - Product is N×N signed, giving 2N bits.
  - Accumulation is 2N-bit two's complement and wraps modulo 2^(2N), with no saturation.
- FSM states:
  - ESPERA:
    - `ocupado` = 0, `coef_dir` = 0.
    - On `muestra_lista` = 1:
      - Shift `x[k] <= x[k-1]`, load `x[0] <= muestra`.
      - Clear `Acum` to 0 and tap index `k` to 0.
      - Go to MAC.
  - MAC:
    - `coef_dir = k`; `Acum <= Acum + coef·x[k]`; `k <= k+1`.
    - After the cycle with k = M-1, go to LISTO.
  - LISTO: go to ESPERA.
- Outputs are registered and decoded from the state:
  - `ban_Adc` = 1 on the first MAC cycle only (k = 0).
  - `ban_Listo` = 1 only in LISTO.
  - `ocupado` = 1 in MAC and LISTO.
- `Acum` holds its final value from LISTO until it is cleared by the next accepted sample.
- The delay line does not shift in MAC or LISTO.
- Samples arriving while `ocupado` = 1 (including in LISTO) are dropped:
  - The delay line is unchanged.
  - `ban_perdida` is set and stays high until `reset`.
- Reset, including mid-MAC:
  - Next state is ESPERA.
  - `Acum`, `x[*]`, `k`, `coef_dir`, `ban_Adc`, `ban_Listo`, `ocupado` and `ban_perdida` all go to 0.
  - Any computation in progress is aborted without a `ban_Listo` pulse.

## Timing
- Strobe sampled at edge t:
  - MAC runs from cycle t+1 to t+M.
  - `ban_Adc` is high during cycle t+1.
  - `ban_Listo` is high during cycle t+M+1.
- Latency from strobe to final result is M+1 cycles.
- Earliest next accepted strobe is at edge t+M+2, i.e. during ESPERA. Maximum throughput is one sample per M+2 cycles.
- Capture register contract:
  - During MAC, `Acum` shows the partial sums.
  - In LISTO, `Acum` shows the final value. `ban_Listo` and the final `Acum` are valid in the same cycle.
- `coef` must be valid combinationally within the cycle in which `coef_dir` is presented.

## Test plan
- Reset: assert `reset` for 2 cycles with random inputs -> all outputs are 0 on the cycle after the first reset edge; state is ESPERA.
- Impulse response: ROM `coef[k] = k+1`, M = 8. Feed sample 1, then seven samples of 0, each strobe in ESPERA -> successive `ban_Listo` results are `Acum` = 1, 2, 3 … 8. `ban_Adc` leads each `ban_Listo` by exactly M = 8 cycles.
- Signed product: all coef = 5. Feed single sample −3 after reset -> `Acum` = −15, sign-extended to 2N bits, at `ban_Listo`.
- Dropped sample: strobe at t, second strobe at t+3 -> second sample is ignored, `ban_perdida` = 1 from t+4 and stays high, result is unaffected. A later strobe in ESPERA is accepted; `ban_perdida` stays 1 until `reset`.
- Reset mid-MAC: assert `reset` at k = 4 -> no `ban_Listo` pulse, all outputs 0. A following sample 1 with `coef[0]` = 1 gives `Acum` = 1, confirming the delay line was cleared.
- Wrap-around: N = 4, M = 8, all coef = −8, eight samples of −8 -> products are 64 each; the sum 512 wraps modulo 256, so `Acum` = 0 at the final `ban_Listo`.
